// File: rtl/mac_beams_sched.sv
// ============================================================================
// mac_beams_sched
// ----------------------------------------------------------------------------
// Sequencing controller in front of the beam MAC datapath. Accepts per-symbol
// antenna RE beats, slices each symbol into RBGs, prefetches the codeword of
// the next RBG into the inactive half of a double-buffered codeword bank, and
// generates the control set the beam MAC consumes. The upstream stream is
// stalled whenever the codeword for the next RBG has not been loaded yet.
//
// Optional feature macro: MAC_SCHED_ERR_EN
//   defined   : o_err pulses on protocol errors, o_err_cnt counts them
//               (16-bit, saturating, cleared by i_rst)
//   undefined : o_err and o_err_cnt tied to 0; errors are still ignored
//
// Parameters
//   RE_PER_RBG    REs per RBG (<= 256)
//   SYMB_PER_SLOT symbols per slot
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_symb_start         pulse, arm a new symbol (accepted only in IDLE)
//   i_slot_start         qualifies i_symb_start: symbol is index 0 of a slot
//   i_num_rbg            RBGs in the symbol, sampled on accepted start
//   i_din_valid          upstream RE beat valid
//   o_din_ready          upstream ready (beat accepted when both high)
//   o_cw_req             one-cycle codeword load request
//   o_cw_rbg             RBG index of the request, held until ack
//   o_cw_bank            bank being loaded while a request is outstanding,
//                        otherwise the bank in use by the datapath
//   i_cw_ack             pulse, requested codeword written
//   o_rvalid/o_sop/o_eop datapath beat, first / last beat of the symbol
//   o_symb_clr           pulse with o_sop of symbol index 0
//   o_symb_1st           high on every beat of symbol index 0
//   o_re_num, o_rbg_num  RE index within RBG, current RBG index
//   o_rbg_load           high on the first beat of each RBG
//   o_busy               controller not idle
//   o_err, o_err_cnt     error pulse and error counter
// ============================================================================
module mac_beams_sched #(
  parameter int RE_PER_RBG    = 48,
  parameter int SYMB_PER_SLOT = 14
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_symb_start,
  input  logic        i_slot_start,
  input  logic [7:0]  i_num_rbg,
  input  logic        i_din_valid,
  output logic        o_din_ready,
  output logic        o_cw_req,
  output logic [7:0]  o_cw_rbg,
  output logic        o_cw_bank,
  input  logic        i_cw_ack,
  output logic        o_rvalid,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_symb_clr,
  output logic        o_symb_1st,
  output logic [7:0]  o_re_num,
  output logic [7:0]  o_rbg_num,
  output logic        o_rbg_load,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_err_cnt
);

  localparam int              SW        = (SYMB_PER_SLOT > 1) ? $clog2(SYMB_PER_SLOT) : 1;
  localparam logic [7:0]      RE_LAST   = 8'(RE_PER_RBG - 1);
  localparam logic [SW-1:0]   SYMB_LAST = SW'(SYMB_PER_SLOT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CW = 2'd1,
    RUN     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      num_rbg_q, num_rbg_d;
  logic [7:0]      rbg_q, rbg_d;
  logic [7:0]      re_q, re_d;
  logic [SW-1:0]   symb_idx_q, symb_idx_d;
  logic            bank_q, bank_d;            // bank the datapath reads
  logic            req_bank_q, req_bank_d;    // bank of the outstanding request
  logic            req_pending_q, req_pending_d;
  logic            pf_acked_q, pf_acked_d;    // next RBG's codeword already loaded
  logic            cw_req_q, cw_req_d;
  logic [7:0]      cw_rbg_q, cw_rbg_d;

  logic            rvalid_q, rvalid_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic            symb_clr_q, symb_clr_d;
  logic            symb_1st_q, symb_1st_d;
  logic [7:0]      re_num_q, re_num_d;
  logic [7:0]      rbg_num_q, rbg_num_d;
  logic            rbg_load_q, rbg_load_d;

  logic            beat;
  logic            ack_ok;
  logic            last_rbg;
  logic [7:0]      rbg_inc;

  assign beat     = (state_q == RUN) && i_din_valid;
  assign ack_ok   = i_cw_ack && req_pending_q;
  assign rbg_inc  = rbg_q + 8'd1;
  assign last_rbg = (rbg_inc == num_rbg_q);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      num_rbg_q     <= '0;
      rbg_q         <= '0;
      re_q          <= '0;
      symb_idx_q    <= SYMB_LAST;   // next non-slot symbol becomes index 0
      bank_q        <= 1'b0;
      req_bank_q    <= 1'b0;
      req_pending_q <= 1'b0;
      pf_acked_q    <= 1'b0;
      cw_req_q      <= 1'b0;
      cw_rbg_q      <= '0;
      rvalid_q      <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      symb_clr_q    <= 1'b0;
      symb_1st_q    <= 1'b0;
      re_num_q      <= '0;
      rbg_num_q     <= '0;
      rbg_load_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_rbg_q     <= num_rbg_d;
      rbg_q         <= rbg_d;
      re_q          <= re_d;
      symb_idx_q    <= symb_idx_d;
      bank_q        <= bank_d;
      req_bank_q    <= req_bank_d;
      req_pending_q <= req_pending_d;
      pf_acked_q    <= pf_acked_d;
      cw_req_q      <= cw_req_d;
      cw_rbg_q      <= cw_rbg_d;
      rvalid_q      <= rvalid_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      symb_clr_q    <= symb_clr_d;
      symb_1st_q    <= symb_1st_d;
      re_num_q      <= re_num_d;
      rbg_num_q     <= rbg_num_d;
      rbg_load_q    <= rbg_load_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    num_rbg_d     = num_rbg_q;
    rbg_d         = rbg_q;
    re_d          = re_q;
    symb_idx_d    = symb_idx_q;
    bank_d        = bank_q;
    req_bank_d    = req_bank_q;
    req_pending_d = req_pending_q;
    pf_acked_d    = pf_acked_q;
    cw_req_d      = 1'b0;
    cw_rbg_d      = cw_rbg_q;
    rvalid_d      = 1'b0;
    sop_d         = 1'b0;
    eop_d         = 1'b0;
    symb_clr_d    = 1'b0;
    symb_1st_d    = 1'b0;
    re_num_d      = '0;
    rbg_num_d     = '0;
    rbg_load_d    = 1'b0;

    // An ack retires the outstanding request; in RUN it is a prefetch ack
    // that the next RBG boundary will consume.
    if (ack_ok) begin
      req_pending_d = 1'b0;
      if (state_q == RUN) pf_acked_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (i_symb_start && (i_num_rbg != 8'd0)) begin
          num_rbg_d     = i_num_rbg;
          if (i_slot_start || (symb_idx_q == SYMB_LAST)) symb_idx_d = '0;
          else                                           symb_idx_d = symb_idx_q + 1'b1;
          rbg_d         = '0;
          re_d          = '0;
          cw_req_d      = 1'b1;
          cw_rbg_d      = '0;
          req_bank_d    = 1'b0;
          req_pending_d = 1'b1;
          pf_acked_d    = 1'b0;
          state_d       = WAIT_CW;
        end
      end

      WAIT_CW: begin
        if (ack_ok) begin
          bank_d  = req_bank_q;
          state_d = RUN;
        end
      end

      RUN: begin
        if (beat) begin
          rvalid_d   = 1'b1;
          sop_d      = (rbg_q == 8'd0) && (re_q == 8'd0);
          eop_d      = last_rbg && (re_q == RE_LAST);
          symb_1st_d = (symb_idx_q == '0);
          symb_clr_d = sop_d && symb_1st_d;
          re_num_d   = re_q;
          rbg_num_d  = rbg_q;
          rbg_load_d = (re_q == 8'd0);

          // Prefetch the next RBG's codeword into the bank not in use.
          if ((re_q == 8'd0) && !last_rbg) begin
            cw_req_d      = 1'b1;
            cw_rbg_d      = rbg_inc;
            req_bank_d    = ~bank_q;
            req_pending_d = 1'b1;
            pf_acked_d    = 1'b0;
          end

          if (re_q == RE_LAST) begin
            re_d = '0;
            if (last_rbg) begin
              state_d = IDLE;
            end else begin
              rbg_d = rbg_inc;
              // An ack landing on the boundary beat itself counts as loaded.
              if (pf_acked_q || ack_ok) begin
                bank_d     = ~bank_q;
                pf_acked_d = 1'b0;
              end else begin
                state_d = WAIT_CW;
              end
            end
          end else begin
            re_d = re_q + 8'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_din_ready = (state_q == RUN);
    o_busy      = (state_q != IDLE);
    o_cw_bank   = req_pending_q ? req_bank_q : bank_q;
  end

  assign o_cw_req   = cw_req_q;
  assign o_cw_rbg   = cw_rbg_q;
  assign o_rvalid   = rvalid_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_symb_clr = symb_clr_q;
  assign o_symb_1st = symb_1st_q;
  assign o_re_num   = re_num_q;
  assign o_rbg_num  = rbg_num_q;
  assign o_rbg_load = rbg_load_q;

`ifdef MAC_SCHED_ERR_EN
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Start while busy, start with zero RBGs, or ack with nothing outstanding.
  always_comb begin
    err_d = (i_symb_start && ((state_q != IDLE) || (i_num_rbg == 8'd0))) ||
            (i_cw_ack && !req_pending_q);
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
`else
  assign o_err     = 1'b0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: doc/mac_beams_sched.md
# mac_beams_sched

Sequencing controller in front of the beam MAC datapath. Accepts per-symbol antenna RE beats from the antenna buffer, slices each symbol into RBGs, prefetches per-RBG codewords into a double-buffered codeword bank, and produces the rvalid/sop/eop/symb_clr/symb_1st/re_num/rbg_num/rbg_load control set the beam MAC consumes. Stalls the upstream stream whenever the codeword for the next RBG is not yet loaded.

## Interface
Parameters:
- RE_PER_RBG, 48, REs per RBG (4 PRB × 12); must be ≤ 256
- SYMB_PER_SLOT, 14, symbols per slot

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_symb_start  in  1  pulse; arm a new symbol
- i_slot_start  in  1  qualifies i_symb_start; symbol is index 0 of a slot
- i_num_rbg  in  8  RBGs in this symbol; sampled on accepted i_symb_start
- i_din_valid  in  1  upstream RE beat valid
- o_din_ready  out  1  upstream ready; beat accepted when both high
- o_cw_req  out  1  one-cycle codeword load request
- o_cw_rbg  out  8  RBG index of the request; held until ack
- o_cw_bank  out  1  bank to load (request) / bank in use (datapath)
- i_cw_ack  in  1  pulse; requested codeword written
- o_rvalid, o_sop, o_eop  out  1 each  datapath beat, first beat, last beat of symbol
- o_symb_clr  out  1  pulse with o_sop of symbol index 0
- o_symb_1st  out  1  high on every beat of symbol index 0
- o_re_num  out  8  RE index within RBG
- o_rbg_num  out  8  current RBG index
- o_rbg_load  out  1  high on first beat of each RBG
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  one-cycle error pulse

## Operation
- States: IDLE, WAIT_CW, RUN.
- IDLE: o_din_ready=0. On i_symb_start with i_num_rbg≠0: latch num_rbg, symbol index (0 if i_slot_start, else previous+1 wrapping SYMB_PER_SLOT-1→0), rbg=0, re=0; issue o_cw_req for RBG 0 into bank 0; → WAIT_CW. i_num_rbg=0: o_err, stay IDLE.
- WAIT_CW: o_din_ready=0; on i_cw_ack → RUN, active bank = requested bank.
- RUN: o_din_ready=1. Each accepted beat increments re; at re=RE_PER_RBG-1 re wraps to 0, rbg increments.
- Prefetch: on first accepted beat of RBG r with r+1<num_rbg, issue o_cw_req for r+1 into the inactive bank.
- RBG boundary (last beat of r, not last RBG): if prefetch acked → swap bank, stay RUN (no bubble); else → WAIT_CW, swap on ack.
- Last beat of last RBG: o_eop, → IDLE.
- i_symb_start when not IDLE: ignored, o_err pulse. i_cw_ack with no outstanding request: ignored, o_err pulse.
- Simultaneous ack and boundary beat in the same cycle: counts as acked.

## Timing
- Datapath outputs (o_rvalid, o_sop, o_eop, o_symb_*, o_re_num, o_rbg_num, o_rbg_load) registered: 1 cycle after the accepted beat.
- o_cw_req 1 cycle after trigger (i_symb_start or first beat of RBG).
- WAIT_CW→RUN: o_din_ready high the cycle after i_cw_ack.
- Reset values: all outputs 0, state IDLE, bank 0, symbol index SYMB_PER_SLOT-1 (next non-slot symbol is index 0). Reset mid-symbol aborts at once; no o_eop emitted; outstanding request dropped.

## Configuration
- MAC_SCHED_ERR_EN defined: o_err driven as above, plus a 16-bit saturating counter of o_err pulses (o_err_cnt), cleared by i_rst.
- Undefined: o_err and o_err_cnt tied to 0; error conditions still ignored identically.

## Test plan
- Reset, i_slot_start+i_symb_start, num_rbg=2, ack after 3 cycles, continuous valid -> 96 beats, o_sop on beat 0 with o_symb_clr and o_symb_1st, o_rbg_load at beats 0 and 48, o_eop at beat 95, rbg_num 0/1, bank 0 then 1.
- Same, delay prefetch ack 10 cycles past beat 47 -> o_din_ready low 10 cycles, no beat lost, re_num restarts at 0 with rbg_num=1.
- Four symbols without slot_start after a slot start -> o_symb_1st only in first, symbol index 0..3; 14 symbols wrap to 0.
- i_symb_start mid-symbol and num_rbg=0 -> o_err pulses, stream unaffected; with MAC_SCHED_ERR_EN o_err_cnt=2.
- i_rst asserted at beat 30 -> next cycle all outputs 0, IDLE; new symbol then runs cleanly from bank 0.
- Ack coincident with boundary beat -> no stall cycle.
